// File: rtl/spr_write_arbiter.sv
// spr_write_arbiter: round-robin arbiter sharing the SPR register-file write
// port among REQUESTERS completing units. The winning result is registered
// onto the write port, so writes appear one cycle after the transfer.
// Contended cycles are counted in a saturating performance counter.
// Optional build macro SPR_WRITE_ADDR_FILTER_EN: when defined, a granted result
// whose SPR number is not XER(1), LR(8) or CTR(9) is consumed without being
// written, and the sticky illegal_addr flag is raised.
module spr_write_arbiter #(
   parameter int unsigned REQUESTERS  = 4,
   parameter int unsigned RS_ID_WIDTH = 5
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   req_valid [REQUESTERS],
   output logic                   req_ready [REQUESTERS],
   input  logic [9:0]             req_addr  [REQUESTERS],
   input  logic [31:0]            req_value [REQUESTERS],
   input  logic [RS_ID_WIDTH-1:0] req_rs_id [REQUESTERS],
   input  logic                   flush,
   output logic [9:0]             write_addr,
   output logic                   write_enable,
   output logic [31:0]            write_value,
   output logic [RS_ID_WIDTH-1:0] write_rs_id,
   output logic [15:0]            conflict_count,
   output logic                   illegal_addr
);

   localparam int unsigned PTR_W = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;
   localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(REQUESTERS - 1);

   logic [PTR_W-1:0]       rr_ptr;
   logic [PTR_W-1:0]       grant_idx;
   logic                   grant;
   logic                   multi_valid;
   logic                   addr_ok;
   logic [9:0]             sel_addr;
   logic [31:0]            sel_value;
   logic [RS_ID_WIDTH-1:0] sel_rs_id;

   // Round-robin scan starting at rr_ptr; flush and reset suppress the grant.
   always_comb begin
      int unsigned idx;
      grant     = 1'b0;
      grant_idx = '0;
      idx       = 0;
      for (int unsigned i = 0; i < REQUESTERS; i++) begin
         idx = (32'(rr_ptr) + i) % REQUESTERS;
         if (!grant && req_valid[PTR_W'(idx)]) begin
            grant     = 1'b1;
            grant_idx = PTR_W'(idx);
         end
      end
      if (rst || flush) begin
         grant = 1'b0;
      end
   end

   // One-hot ready to the winning requester only.
   always_comb begin
      for (int unsigned i = 0; i < REQUESTERS; i++) begin
         req_ready[i] = grant && (grant_idx == PTR_W'(i));
      end
   end

   // Detect two or more simultaneous requests for the conflict counter.
   always_comb begin
      logic seen;
      seen        = 1'b0;
      multi_valid = 1'b0;
      for (int unsigned i = 0; i < REQUESTERS; i++) begin
         if (req_valid[i]) begin
            if (seen) begin
               multi_valid = 1'b1;
            end
            seen = 1'b1;
         end
      end
   end

   assign sel_addr  = req_addr[grant_idx];
   assign sel_value = req_value[grant_idx];
   assign sel_rs_id = req_rs_id[grant_idx];

`ifdef SPR_WRITE_ADDR_FILTER_EN
   // Only XER, LR and CTR are backed by the register file.
   assign addr_ok = (sel_addr == 10'd1) || (sel_addr == 10'd8) || (sel_addr == 10'd9);
`else
   assign addr_ok = 1'b1;
`endif

   // Pointer, registered write port, conflict counter and sticky error flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr         <= '0;
         write_enable   <= 1'b0;
         write_addr     <= '0;
         write_value    <= '0;
         write_rs_id    <= '0;
         conflict_count <= '0;
         illegal_addr   <= 1'b0;
      end else begin
         write_enable <= grant && addr_ok;
         if (grant) begin
            rr_ptr <= (grant_idx == LAST_IDX) ? '0 : grant_idx + PTR_W'(1);
         end
         if (grant && addr_ok) begin
            write_addr  <= sel_addr;
            write_value <= sel_value;
            write_rs_id <= sel_rs_id;
         end
         if (grant && !addr_ok) begin
            illegal_addr <= 1'b1;
         end
         if (!flush && multi_valid && (conflict_count != 16'hFFFF)) begin
            conflict_count <= conflict_count + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_spr_write_arbiter.sv
// Scoreboard bench for spr_write_arbiter: stimulus pushes expected writes,
// a negedge monitor pops and compares every write the DUT presents.
module tb_spr_write_arbiter;

   localparam int unsigned N  = 4;
   localparam int unsigned RW = 5;

   typedef struct packed {
      logic [9:0]    a;
      logic [31:0]   v;
      logic [RW-1:0] r;
   } wr_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          flush = 1'b0;
   logic          req_valid [N];
   logic          req_ready [N];
   logic [9:0]    req_addr  [N];
   logic [31:0]   req_value [N];
   logic [RW-1:0] req_rs_id [N];
   logic [9:0]    write_addr;
   logic          write_enable;
   logic [31:0]   write_value;
   logic [RW-1:0] write_rs_id;
   logic [15:0]   conflict_count;
   logic          illegal_addr;
   logic [3:0]    rdy;

   wr_t exp_q[$];
   wr_t got;
   wr_t want;
   int  checks = 0;
   int  errors = 0;

   always #5 clk = ~clk;

   spr_write_arbiter #(.REQUESTERS(N), .RS_ID_WIDTH(RW)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_addr(req_addr), .req_value(req_value), .req_rs_id(req_rs_id),
      .flush(flush),
      .write_addr(write_addr), .write_enable(write_enable),
      .write_value(write_value), .write_rs_id(write_rs_id),
      .conflict_count(conflict_count), .illegal_addr(illegal_addr)
   );

   always_comb begin
      for (int i = 0; i < 4; i++) rdy[i] = req_ready[i];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   task automatic set_req(input int i, input logic [9:0] a, input logic [31:0] v,
                          input logic [RW-1:0] r);
      req_valid[i] = 1'b1;
      req_addr[i]  = a;
      req_value[i] = v;
      req_rs_id[i] = r;
   endtask

   task automatic push(input logic [9:0] a, input logic [31:0] v, input logic [RW-1:0] r);
      wr_t e;
      e.a = a;
      e.v = v;
      e.r = r;
      exp_q.push_back(e);
   endtask

   task automatic clear_all();
      for (int i = 0; i < N; i++) req_valid[i] = 1'b0;
   endtask

   // Monitor: every presented write must match the oldest expected write.
   always @(negedge clk) begin
      if (write_enable === 1'b1) begin
         checks++;
         got.a = write_addr;
         got.v = write_value;
         got.r = write_rs_id;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL wr_unexpected actual=%h required=none", got);
         end else begin
            want = exp_q.pop_front();
            if (got !== want) begin
               errors++;
               $display("FAIL wr_payload actual=%h required=%h", got, want);
            end
         end
      end
   end

   // Watchdog so the run always ends.
   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [9:0]    pa [4];
      logic [31:0]   pv [4];
      logic [RW-1:0] pr [4];
      pa[0] = 10'd1; pa[1] = 10'd8; pa[2] = 10'd9; pa[3] = 10'd1;
      for (int i = 0; i < 4; i++) begin
         pv[i] = 32'h1000_0000 + 32'(i);
         pr[i] = RW'(i + 10);
      end
      for (int i = 0; i < N; i++) begin
         req_valid[i] = 1'b1;
         req_addr[i]  = '0;
         req_value[i] = '0;
         req_rs_id[i] = '0;
      end

      // Reset: no grants while rst is high even with all requests valid.
      step();
      sample();
      chk("ready_in_reset", 32'(rdy), 32'h0);
      step();
      rst = 1'b0;
      clear_all();
      sample();
      chk("reset_we", 32'(write_enable), 32'h0);
      chk("reset_conflict", 32'(conflict_count), 32'h0);
      chk("reset_illegal", 32'(illegal_addr), 32'h0);

      // Single request from requester 2.
      step();
      set_req(2, 10'd8, 32'hDEADBEEF, 5'd5);
      sample();
      chk("t1_ready", 32'(rdy), 32'h4);
      push(10'd8, 32'hDEADBEEF, 5'd5);
      step();
      clear_all();
      sample();
      chk("t1_we", 32'(write_enable), 32'h1);

      // Pointer at 3, only requester 1: wraps to 1, pointer then 2.
      step();
      set_req(1, 10'd9, 32'h1111_1111, 5'd1);
      sample();
      chk("t4_ready", 32'(rdy), 32'h2);
      push(10'd9, 32'h1111_1111, 5'd1);
      step();
      set_req(1, 10'd1, 32'h2222_2222, 5'd2);
      set_req(3, 10'd8, 32'h3333_3333, 5'd3);
      sample();
      chk("t4_ptr2_ready", 32'(rdy), 32'h8);
      push(10'd8, 32'h3333_3333, 5'd3);
      step();
      req_valid[3] = 1'b0;
      sample();
      chk("t4_wrap_ready", 32'(rdy), 32'h2);
      push(10'd1, 32'h2222_2222, 5'd2);
      step();
      clear_all();
      sample();
      chk("t4_conflict", 32'(conflict_count), 32'h1);

      // Reset, then all four valid: grants 0,1,2,3,0 with back-to-back writes.
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) set_req(i, pa[i], pv[i], pr[i]);
      for (int k = 0; k < 5; k++) begin
         sample();
         chk("t2_grant", 32'(rdy), 32'(1 << (k % 4)));
         push(pa[k % 4], pv[k % 4], pr[k % 4]);
         if (k > 0) chk("t2_we", 32'(write_enable), 32'h1);
         step();
      end
      clear_all();
      sample();
      chk("t2_we_last", 32'(write_enable), 32'h1);
      chk("t2_conflict", 32'(conflict_count), 32'h5);

      // Flush for two cycles with requester 1 pending (pointer at 1).
      step();
      set_req(1, 10'd8, 32'hF1F1_F1F1, 5'd9);
      flush = 1'b1;
      sample();
      chk("t3_ready_f0", 32'(rdy), 32'h0);
      chk("t3_we_f0", 32'(write_enable), 32'h0);
      step();
      sample();
      chk("t3_ready_f1", 32'(rdy), 32'h0);
      chk("t3_we_f1", 32'(write_enable), 32'h0);
      step();
      flush = 1'b0;
      sample();
      chk("t3_ready_after", 32'(rdy), 32'h2);
      push(10'd8, 32'hF1F1_F1F1, 5'd9);
      step();
      clear_all();
      sample();
      chk("t3_conflict", 32'(conflict_count), 32'h5);

      // Grant in cycle N, reset at the closing edge: write dropped.
      step();
      set_req(2, 10'd9, 32'hBAD0_BAD0, 5'd4);
      sample();
      chk("t5_ready", 32'(rdy), 32'h4);
      rst = 1'b1;
      step();
      rst = 1'b0;
      clear_all();
      sample();
      chk("t5_we", 32'(write_enable), 32'h0);
      chk("t5_conflict", 32'(conflict_count), 32'h0);
      step();
      set_req(1, 10'd1, 32'h5555_AAAA, 5'd6);
      set_req(3, 10'd9, 32'h6666_BBBB, 5'd7);
      sample();
      chk("t5_ptr0_ready", 32'(rdy), 32'h2);
      push(10'd1, 32'h5555_AAAA, 5'd6);
      step();
      clear_all();
      sample();

      // Address 3 from requester 0 (pointer at 2 wraps to 0).
      step();
      set_req(0, 10'd3, 32'hCAFE_F00D, 5'd7);
      sample();
      chk("t6_ready", 32'(rdy), 32'h1);
`ifndef SPR_WRITE_ADDR_FILTER_EN
      push(10'd3, 32'hCAFE_F00D, 5'd7);
`endif
      step();
      clear_all();
      sample();
`ifdef SPR_WRITE_ADDR_FILTER_EN
      chk("t6_we", 32'(write_enable), 32'h0);
      chk("t6_illegal", 32'(illegal_addr), 32'h1);
      step();
      sample();
      chk("t6_illegal_sticky", 32'(illegal_addr), 32'h1);
`else
      chk("t6_we", 32'(write_enable), 32'h1);
      chk("t6_illegal", 32'(illegal_addr), 32'h0);
      step();
      sample();
      chk("t6_illegal_hold", 32'(illegal_addr), 32'h0);
`endif
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      sample();
      chk("t6_illegal_reset", 32'(illegal_addr), 32'h0);
      chk("queue_drained", 32'(exp_q.size()), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
